// File: rtl/serial_addsub_if.sv
// Start/done bus of the bit-serial adder/subtractor.
// start is taken only while busy=0; done pulses for one cycle when sum/cout/ovf are new.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one full-adder slice and a registered carry, LSB first,
// one bit per clock; result registers hold the last completed operation.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_addsub_if.slave   bus,
    output logic             o_dbg_state
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;
    logic             r_cout;
    logic             r_ovf;

    logic w_s;
    logic w_carry;

    assign w_s     = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_carry = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Subtraction is a + ~b + 1: invert B here and seed the carry with 1.
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.sub ? ~bus.b : bus.b;
                        r_carry <= bus.sub;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_carry <= w_carry;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_res   <= {w_s, r_res[WIDTH-1:1]};
                    r_cnt   <= r_cnt + CW'(1);
                    // On the MSB edge r_carry is still the carry into the MSB.
                    if (r_cnt == CNT_LAST) begin
                        r_sum   <= {w_s, r_res[WIDTH-1:1]};
                        r_cout  <= w_carry;
                        r_ovf   <= r_carry ^ w_carry;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.sum     = r_sum;
    assign bus.cout    = r_cout;
    assign bus.ovf     = r_ovf;
    assign o_dbg_state = r_state[0];
endmodule
